// File: rtl/bist_2806_pkg.sv
// Shared types and constants for the TopLevel2806 self-test controller:
// FSM states, bus widths, MISR polynomial and LFSR feedback taps.
package bist_2806_pkg;

  localparam int unsigned LFSR_W = 4;
  localparam int unsigned MISR_W = 8;
  localparam int unsigned RESP_W = 3;

  localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

  // x^4+x^3+1: feedback from the two top LFSR bits
  localparam int unsigned LFSR_TAP_A = 3;
  localparam int unsigned LFSR_TAP_B = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register folding the DUT response bus into an
// 8-bit signature; also exposes the value it will hold after this edge.
module misr_compactor
  import bist_2806_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [MISR_W-1:0] sig,
  output logic [MISR_W-1:0] sig_next_c
);

  logic [MISR_W-1:0] upd_c;

  always_comb begin
    upd_c      = {sig[MISR_W-2:0], 1'b0}
               ^ (sig[MISR_W-1] ? MISR_POLY : MISR_W'(0))
               ^ MISR_W'(resp);
    sig_next_c = en ? upd_c : sig;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= upd_c;
    end
  end

endmodule

// File: rtl/bist_ctrl_2806.sv
// Self-test controller: drives LFSR patterns into TopLevel2806, compacts the
// pipelined responses in a MISR and flags pass against a golden signature.
module bist_ctrl_2806
  import bist_2806_pkg::*;
#(
  parameter int unsigned        PAT_COUNT  = 64,
  parameter int unsigned        PIPE_LAT   = 2,
  parameter logic [LFSR_W-1:0]  SEED       = 4'b0001,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic [LFSR_W-1:0] pat_out,
  input  logic [RESP_W-1:0] resp_in,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic              pass
);

  localparam int unsigned CNT_W = 16;
  // an all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  state_e              state;
  logic [LFSR_W-1:0]   lfsr;
  logic [CNT_W-1:0]    count;
  logic [PIPE_LAT-1:0] vpipe;
  logic                misr_clr_c;
  logic [MISR_W-1:0]   sig_next_c;

  assign misr_clr_c = RST | (start & ((state == IDLE) | (state == DONE)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      lfsr    <= '0;
      count   <= '0;
      vpipe   <= '0;
      pat_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      // delayed copy of "pattern on the bus" marks when its response is due
      vpipe <= PIPE_LAT'({vpipe, state == RUN});
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            lfsr    <= SEED_EFF;
            pat_out <= SEED_EFF;
            count   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        RUN: begin
          lfsr  <= lfsr_next(lfsr);
          count <= count + 1'b1;
          if (count == CNT_W'(PAT_COUNT - 1)) begin
            state   <= FLUSH;
            count   <= '0;
            pat_out <= '0;
          end else begin
            pat_out <= lfsr_next(lfsr);
          end
        end
        FLUSH: begin
          count <= count + 1'b1;
          // final MISR update lands on this same edge, so judge its next value
          if (count == CNT_W'(PIPE_LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next_c == GOLDEN_SIG);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  misr_compactor u_misr (
    .clk        (CLK),
    .clr        (misr_clr_c),
    .en         (vpipe[PIPE_LAT-1]),
    .resp       (resp_in),
    .sig        (signature),
    .sig_next_c (sig_next_c)
  );

endmodule
